// File: rtl/hci_queue_ch.sv
// Circular-buffer queue channel with clamped threshold trigger, occupancy
// high-water mark and a one-cycle flush sequence.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal operation, pushes and pops accepted
// ST_FLUSH | one-cycle flush, queue already empty, flush_ack_o asserted
module hci_queue_ch #(
   parameter  int Width    = 32,
   parameter  int Depth    = 64,
   parameter  int ThldMode = 0,
   localparam int CntW     = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o,
   input  logic [CntW-1:0]  thld_i,
   output logic [CntW-1:0]  thld_o,
   output logic             thld_trig_o,
   output logic [CntW-1:0]  count_o,
   output logic [CntW-1:0]  peak_o,
   output logic             full_o,
   output logic             empty_o,
   input  logic             flush_req_i,
   output logic             flush_ack_o
);

   localparam int              PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [CntW-1:0] DepthC = CntW'(Depth);
   localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);

   typedef enum logic {ST_RUN, ST_FLUSH} state_e;

   state_e           state_q, state_d;
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [CntW-1:0]  peak_q, peak_d;
   logic [Width-1:0] mem_q [Depth];

   logic in_run, flush_go, push, pop;

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      peak_d      = peak_q;
      in_run      = (state_q == ST_RUN);
      full_o      = (count_q == DepthC);
      empty_o     = (count_q == '0);
      wready_o    = in_run && !full_o;
      rvalid_o    = in_run && !empty_o;
      flush_ack_o = (state_q == ST_FLUSH);
      flush_go    = in_run && flush_req_i;
      // A flush request discards any transfer handshaken in the same cycle.
      push        = wvalid_i && wready_o && !flush_go;
      pop         = rvalid_o && rready_i && !flush_go;

      case (state_q)
         ST_RUN:   if (flush_go) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase

      if (flush_go) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         peak_d  = '0;
      end else begin
         if (push) wptr_d = (wptr_q == PtrMax) ? '0 : wptr_q + 1'b1;
         if (pop)  rptr_d = (rptr_q == PtrMax) ? '0 : rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         peak_d = (count_d > peak_q) ? count_d : peak_q;
      end
   end

   always_comb begin
      if (thld_i == '0)          thld_o = CntW'(1);
      else if (thld_i > DepthC)  thld_o = DepthC;
      else                       thld_o = thld_i;

      if (ThldMode == 0) thld_trig_o = in_run && ((DepthC - count_q) >= thld_o);
      else               thld_trig_o = in_run && (count_q >= thld_o);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_RUN;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         peak_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         peak_q  <= peak_d;
      end
   end

   // Storage carries no reset; the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;
   assign peak_o  = peak_q;

endmodule

// File: tb/tb_hci_queue_ch.sv
// Directed bench for hci_queue_ch (Width=32, Depth=8): a SW-fill and a
// SW-drain instance share stimulus; a queue model tracks data and counts.
module tb_hci_queue_ch;

   localparam int W = 32;
   localparam int D = 8;
   localparam int C = 4;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         wvalid_i, rready_i, flush_req_i;
   logic [W-1:0] wdata_i;
   logic [C-1:0] thld_i;

   logic         wready, rvalid, trig0, full, empty, ack;
   logic [W-1:0] rdata;
   logic [C-1:0] thld_o, count, peak;

   logic         wready1, rvalid1, trig1, full1, empty1, ack1;
   logic [W-1:0] rdata1;
   logic [C-1:0] thld_o1, count1, peak1;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] q[$];
   int peak_m = 0;

   always #5 clk_i = ~clk_i;

   hci_queue_ch #(.Width(W), .Depth(D), .ThldMode(0)) dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .wvalid_i(wvalid_i), .wready_o(wready),
      .wdata_i(wdata_i), .rvalid_o(rvalid), .rready_i(rready_i), .rdata_o(rdata),
      .thld_i(thld_i), .thld_o(thld_o), .thld_trig_o(trig0), .count_o(count),
      .peak_o(peak), .full_o(full), .empty_o(empty), .flush_req_i(flush_req_i),
      .flush_ack_o(ack));

   hci_queue_ch #(.Width(W), .Depth(D), .ThldMode(1)) dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .wvalid_i(wvalid_i), .wready_o(wready1),
      .wdata_i(wdata_i), .rvalid_o(rvalid1), .rready_i(rready_i), .rdata_o(rdata1),
      .thld_i(thld_i), .thld_o(thld_o1), .thld_trig_o(trig1), .count_o(count1),
      .peak_o(peak1), .full_o(full1), .empty_o(empty1), .flush_req_i(flush_req_i),
      .flush_ack_o(ack1));

   typedef struct {
      logic         wv;
      logic         rr;
      logic [C-1:0] thld;
      logic [C-1:0] e_cnt;
      logic [C-1:0] e_thld;
      logic         e_t0;
      logic         e_t1;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock with the given inputs, checked against the queue model.
   task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr);
      logic push_ok, pop_ok;
      wvalid_i = wv;
      wdata_i  = wd;
      rready_i = rr;
      #1;
      chk("wready", {31'b0, wready}, {31'b0, q.size() < D});
      chk("rvalid", {31'b0, rvalid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
         chk("rdata", rdata, q[0]);
         chk("rdata1", rdata1, q[0]);
      end
      push_ok = wv && (q.size() < D);
      pop_ok  = rr && (q.size() != 0);
      @(posedge clk_i);
      #1;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(wd);
      if (q.size() > peak_m) peak_m = q.size();
      chk("count", {28'b0, count}, q.size());
      chk("peak", {28'b0, peak}, peak_m);
      chk("full", {31'b0, full}, {31'b0, q.size() == D});
      chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 4'd3,  4'd1, 4'd3, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'd3,  4'd2, 4'd3, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 4'd3,  4'd3, 4'd3, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 4'd12, 4'd3, 4'd8, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'd12, 4'd4, 4'd8, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'd12, 4'd5, 4'd8, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 4'd12, 4'd6, 4'd8, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'd12, 4'd7, 4'd8, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 4'd12, 4'd8, 4'd8, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 4'd0,  4'd7, 4'd1, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 4'd9,  4'd6, 4'd8, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 4'd2,  4'd5, 4'd2, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 4'd6,  4'd4, 4'd6, 1'b0, 1'b0};

      rst_ni = 1'b0;
      wvalid_i = 1'b0; rready_i = 1'b0; flush_req_i = 1'b0;
      wdata_i = '0; thld_i = '0;
      #12;
      chk("rst_thld_o", {28'b0, thld_o}, 32'd1);
      chk("rst_trig0", {31'b0, trig0}, 32'd1);
      chk("rst_trig1", {31'b0, trig1}, 32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_wready", {31'b0, wready}, 32'd1);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_count", {28'b0, count}, 32'd0);
      chk("rst_peak1", {28'b0, peak1}, 32'd0);
      chk("rst_dut1_flags", {26'b0, wready1, rvalid1, full1, empty1, ack1, 1'b0},
          {26'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      chk("rst_thld_o1", {28'b0, thld_o1}, 32'd1);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Fill to full, one rejected write, then drain in order.
      for (int i = 0; i < D; i++) step(1'b1, W'(i), 1'b0);
      chk("full_trig0", {31'b0, trig0}, 32'd0);
      chk("full_trig1", {31'b0, trig1}, 32'd1);
      step(1'b1, 32'h99, 1'b0);
      step(1'b1, 32'hAA, 1'b1);
      for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);

      // Pointer wrap.
      for (int i = 0; i < 6; i++) step(1'b1, 32'h100 + W'(i), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 32'h180 + W'(i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

      // Steady occupancy under simultaneous push and pop.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h1C0 + W'(i), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 32'h1D0 + W'(i), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

      // Threshold clamp and trigger in both modes.
      for (int i = 0; i < 13; i++) begin
         thld_i = tbl[i].thld;
         step(tbl[i].wv, 32'h200 + W'(i), tbl[i].rr);
         chk($sformatf("tbl%0d_count", i), {28'b0, count}, {28'b0, tbl[i].e_cnt});
         chk($sformatf("tbl%0d_count1", i), {28'b0, count1}, {28'b0, tbl[i].e_cnt});
         chk($sformatf("tbl%0d_thld_o", i), {28'b0, thld_o}, {28'b0, tbl[i].e_thld});
         chk($sformatf("tbl%0d_trig0", i), {31'b0, trig0}, {31'b0, tbl[i].e_t0});
         chk($sformatf("tbl%0d_trig1", i), {31'b0, trig1}, {31'b0, tbl[i].e_t1});
      end

      // Flush at count 5 with a concurrent write; a held request is ignored in FLUSH.
      thld_i = 4'd0;
      step(1'b1, 32'h300, 1'b0);
      flush_req_i = 1'b1;
      wvalid_i    = 1'b1;
      wdata_i     = 32'hDEAD;
      rready_i    = 1'b0;
      #1;
      chk("flush_pre_wready", {31'b0, wready}, 32'd1);
      @(posedge clk_i);
      #1;
      chk("flush_ack", {31'b0, ack}, 32'd1);
      chk("flush_count", {28'b0, count}, 32'd0);
      chk("flush_peak", {28'b0, peak}, 32'd0);
      chk("flush_wready", {31'b0, wready}, 32'd0);
      chk("flush_rvalid", {31'b0, rvalid}, 32'd0);
      chk("flush_trig0", {31'b0, trig0}, 32'd0);
      @(posedge clk_i);
      #1;
      chk("post_flush_ack", {31'b0, ack}, 32'd0);
      chk("post_flush_wready", {31'b0, wready}, 32'd1);
      chk("post_flush_count", {28'b0, count}, 32'd0);
      chk("post_flush_trig0", {31'b0, trig0}, 32'd1);
      flush_req_i = 1'b0;
      q.delete();
      peak_m = 0;
      step(1'b1, 32'h55, 1'b0);
      step(1'b0, '0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
